// File: rtl/async_fifo_wr_ctrl_if.sv
// Write-side bundle of the async FIFO: producer handshake, pointer-counter controls and pointers.
// The producer/environment drives through master; the write controller sits on slave.
interface async_fifo_wr_ctrl_if #(
  parameter int COUNTER_SIZE = 4
);
  logic                    wr_valid;
  logic                    wr_ready;
  logic                    mem_wr_en;
  logic                    counter_incr;
  logic                    counter_en;
  logic [COUNTER_SIZE-1:0] wr_gcode_ptr;
  logic [COUNTER_SIZE-1:0] rd_gcode_ptr;
  logic                    full;
  logic                    almost_full;
  logic [COUNTER_SIZE-1:0] wr_level;

  modport master (
    output wr_valid,
    output wr_gcode_ptr,
    output rd_gcode_ptr,
    input  wr_ready,
    input  mem_wr_en,
    input  counter_incr,
    input  counter_en,
    input  full,
    input  almost_full,
    input  wr_level
  );

  modport slave (
    input  wr_valid,
    input  wr_gcode_ptr,
    input  rd_gcode_ptr,
    output wr_ready,
    output mem_wr_en,
    output counter_incr,
    output counter_en,
    output full,
    output almost_full,
    output wr_level
  );
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain controller for the async FIFO: handshake, read-pointer synchroniser, registered full.
// Defining ASYNC_FIFO_WR_ALMOST_FULL_EN adds the registered wr_level / almost_full occupancy outputs.
module async_fifo_wr_ctrl #(
  parameter int COUNTER_SIZE      = 4,
  parameter int SYNC_STAGES       = 2,
  parameter int ALMOST_FULL_LEVEL = 6
) (
  input logic                 clk,
  input logic                 reset_n,
  async_fifo_wr_ctrl_if.slave bus
);

  localparam int DEPTH = 2 ** (COUNTER_SIZE - 1);
  // Full when the next write pointer equals the read pointer with its top two gray bits inverted.
  localparam logic [COUNTER_SIZE-1:0] FULL_MASK = COUNTER_SIZE'(3) << (COUNTER_SIZE - 2);

  if (COUNTER_SIZE < 2 || SYNC_STAGES < 2 ||
      ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_param_check
    $error("async_fifo_wr_ctrl: illegal parameter combination");
  end

  function automatic logic [COUNTER_SIZE-1:0] gray2bin(input logic [COUNTER_SIZE-1:0] g);
    logic [COUNTER_SIZE-1:0] b;
    b[COUNTER_SIZE-1] = g[COUNTER_SIZE-1];
    for (int i = COUNTER_SIZE - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [COUNTER_SIZE-1:0] bin2gray(input logic [COUNTER_SIZE-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [COUNTER_SIZE-1:0] sync_q [SYNC_STAGES];
  logic [COUNTER_SIZE-1:0] rd_gsync;
  logic                    full_q;
  logic                    accept;
  logic [COUNTER_SIZE-1:0] wr_bin;
  logic [COUNTER_SIZE-1:0] wr_bin_next;
  logic [COUNTER_SIZE-1:0] wr_gnext;
  logic                    full_next;

  // The raw read pointer only ever feeds the first synchroniser flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= bus.rd_gcode_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rd_gsync = sync_q[SYNC_STAGES-1];

  always_comb begin
    accept      = bus.wr_valid & ~full_q;
    wr_bin      = gray2bin(bus.wr_gcode_ptr);
    wr_bin_next = wr_bin + COUNTER_SIZE'(accept);
    wr_gnext    = accept ? bin2gray(wr_bin_next) : bus.wr_gcode_ptr;
    full_next   = (wr_gnext == (rd_gsync ^ FULL_MASK));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_next;
    end
  end

  assign bus.wr_ready     = ~full_q;
  assign bus.mem_wr_en    = accept;
  assign bus.counter_incr = bus.wr_valid;
  assign bus.counter_en   = ~full_q;
  assign bus.full         = full_q;

`ifdef ASYNC_FIFO_WR_ALMOST_FULL_EN
  localparam logic [COUNTER_SIZE-1:0] AF_LEVEL = COUNTER_SIZE'(ALMOST_FULL_LEVEL);

  logic [COUNTER_SIZE-1:0] rd_bin;
  logic [COUNTER_SIZE-1:0] level_next;
  logic [COUNTER_SIZE-1:0] level_q;
  logic                    almost_full_q;

  // Occupancy is pessimistic for the same reason full is: the read pointer seen here is stale.
  always_comb begin
    rd_bin     = gray2bin(rd_gsync);
    level_next = wr_bin_next - rd_bin;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      level_q       <= level_next;
      almost_full_q <= (level_next >= AF_LEVEL);
    end
  end

  assign bus.wr_level    = level_q;
  assign bus.almost_full = almost_full_q;
`else
  assign bus.wr_level    = '0;
  assign bus.almost_full = 1'b0;
`endif

endmodule
